// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN        operand/result width (only 32 supported)
//   ITERATIONS  radix-2 steps per operation
//   OP_*        M-extension funct3 encodings
//   state_e     control FSM states
package muldiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // Operand A is signed for MULH, MULHSU, DIV, REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_MULHSU) || (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

  // Operand B is signed for MULH, DIV, REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == OP_MULH) || (f3 == OP_DIV) || (f3 == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/write-back bundle of the multiply/divide unit.
//   master modport: issuing stage (drives start/funct3/rs1_val/rs2_val/rd_in)
//   slave modport : muldiv_unit   (drives busy/we_out/wa_out/wd_out/illegal)
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            we_out;
  logic [4:0]      wa_out;
  logic [XLEN-1:0] wd_out;
  logic            illegal;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, we_out, wa_out, wd_out, illegal
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, we_out, wa_out, wd_out, illegal
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational sign handling for the multiply/divide unit.
//   a_i/b_i, a_signed_i/b_signed_i  raw operands and their signedness
//   a_abs_o/b_abs_o, a_neg_o/b_neg_o magnitude and sign of each operand
//   res_i/res_neg_i -> res_o          64-bit result, two's-complement negated on request
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              a_signed_i,
  input  logic              b_signed_i,
  output logic [XLEN-1:0]   a_abs_o,
  output logic [XLEN-1:0]   b_abs_o,
  output logic              a_neg_o,
  output logic              b_neg_o,
  input  logic [2*XLEN-1:0] res_i,
  input  logic              res_neg_i,
  output logic [2*XLEN-1:0] res_o
);

  always_comb begin
    a_neg_o = a_signed_i & a_i[XLEN-1];
    b_neg_o = b_signed_i & b_i[XLEN-1];
    // 0x80000000 maps onto itself, which is its correct unsigned magnitude.
    a_abs_o = a_neg_o ? ('0 - a_i) : a_i;
    b_abs_o = b_neg_o ? ('0 - b_i) : b_i;
    res_o   = res_neg_i ? ('0 - res_i) : res_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one radix-2 step per cycle,
// fixed 33-cycle latency from acceptance to the write-back strobe.
//   clk, reset     rising-edge clock, synchronous active-high reset
//   io (slave)     start/funct3/rs1_val/rs2_val/rd_in in;
//                  busy/we_out/wa_out/wd_out/illegal out
// Build option: define MULDIV_DIV_EN to include divide hardware. Without it,
// divide funct3 codes complete in one cycle with an illegal pulse and no write.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave io
);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        wa_q, wa_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic              we_q, we_d;
  logic              ill_q, ill_d;
  logic [XLEN-1:0]   op_q, op_d;    // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi_q, hi_d;    // product high word / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;    // product low word+multiplier / dividend+quotient
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              dz_q, dz_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   a_abs, b_abs;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] res_raw, res_fixed;
  logic              res_neg;
  logic [XLEN-1:0]   result;
  logic [XLEN:0]     mul_sum;
  logic              acc_illegal;
  logic              op_illegal;

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;

  assign acc_illegal = 1'b0;
  assign op_illegal  = 1'b0;
  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits; the difference always fits XLEN bits.
  assign rem_sh  = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = (rem_sh >= {1'b0, op_q});
  assign div_sub = rem_sh[XLEN-1:0] - op_q;
`else
  assign acc_illegal = io.funct3[2];
  assign op_illegal  = f3_q[2];
`endif

  // Shift-add step: conditionally add multiplicand to the high word, then
  // shift the 65-bit {carry, hi, lo} right by one.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);

  muldiv_sign_fix u_sign_fix (
    .a_i        (io.rs1_val),
    .b_i        (io.rs2_val),
    .a_signed_i (a_is_signed(io.funct3)),
    .b_signed_i (b_is_signed(io.funct3)),
    .a_abs_o    (a_abs),
    .b_abs_o    (b_abs),
    .a_neg_o    (a_neg),
    .b_neg_o    (b_neg),
    .res_i      (res_raw),
    .res_neg_i  (res_neg),
    .res_o      (res_fixed)
  );

  // Result selection. Remainder takes the dividend sign; quotient and product
  // are negated when operand signs differ. Divide-by-zero remainder falls out
  // of the datapath (|A| with A's sign); only the quotient needs an override.
  always_comb begin
    if (f3_q[2]) begin
      res_raw = {{XLEN{1'b0}}, (f3_q[1] ? hi_q : lo_q)};
      res_neg = f3_q[1] ? sa_q : (sa_q ^ sb_q);
    end else begin
      res_raw = {hi_q, lo_q};
      res_neg = sa_q ^ sb_q;
    end

    if (f3_q[2]) begin
      result = (dz_q && !f3_q[1]) ? '1 : res_fixed[XLEN-1:0];
    end else if (f3_q == OP_MUL) begin
      result = res_fixed[XLEN-1:0];
    end else begin
      result = res_fixed[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    ill_d   = 1'b0;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          f3_d  = io.funct3;
          wa_d  = io.rd_in;
          sa_d  = a_neg;
          sb_d  = b_neg;
          dz_d  = (io.rs2_val == '0);
          cnt_d = '0;
          hi_d  = '0;
          if (io.funct3[2]) begin
            op_d = b_abs;
            lo_d = a_abs;
          end else begin
            op_d = a_abs;
            lo_d = b_abs;
          end
          state_d = acc_illegal ? ST_DONE : ST_CALC;
        end
      end

      ST_CALC: begin
`ifdef MULDIV_DIV_EN
        if (f3_q[2]) begin
          hi_d = div_ge ? div_sub : rem_sh[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else
`endif
        begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        we_d    = !op_illegal;
        ill_d   = op_illegal;
        wd_d    = op_illegal ? '0 : result;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f3_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.busy    = (state_q != ST_IDLE);
  assign io.we_out  = we_q;
  assign io.wa_out  = wa_q;
  assign io.wd_out  = wd_q;
  assign io.illegal = ill_q;

endmodule
